// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the PC, selects the next PC (sequential, relative
// branch or register target), and tracks RUN/HALTED state and retired instructions.
module pc_sequencer #(
  parameter logic [63:0] RESET_VEC = 64'h0,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             cond_br,
  input  logic             br_taken,
  input  logic             uncond_br,
  input  logic             br_reg,
  input  logic [18:0]      imm19,
  input  logic [25:0]      imm26,
  input  logic [63:0]      reg_target,
  output logic [63:0]      pc,
  output logic [63:0]      link_addr,
  output logic [1:0]       next_sel,
  output logic             running,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      next_pc;
  logic [63:0]      off19, off26;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Word offsets: sign-extend and scale by 4 in one concatenation.
  assign off19 = {{43{imm19[18]}}, imm19, 2'b00};
  assign off26 = {{36{imm26[25]}}, imm26, 2'b00};

  assign link_addr = pc_q + 64'd4;

  always_comb begin
    next_sel = 2'd0;
    if (br_reg)                   next_sel = 2'd3;
    else if (uncond_br)           next_sel = 2'd2;
    else if (cond_br && br_taken) next_sel = 2'd1;
  end

  always_comb begin
    next_pc = pc_q + 64'd4;
    case (next_sel)
      2'd1:    next_pc = pc_q + off19;
      2'd2:    next_pc = pc_q + off26;
      2'd3:    next_pc = reg_target;
      default: next_pc = pc_q + 64'd4;
    endcase
  end

  // In RUN, stall beats halt; a halting instruction still retires.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      RUN: begin
        if (!stall) begin
          pc_d      = next_pc;
          retired_d = retired_q + CNT_ONE;
          if (halt) state_d = HALTED;
        end
      end
      HALTED: begin
        if (resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VEC;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign pc      = pc_q;
  assign running = (state_q == RUN);
  assign retired = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized cycles, checked
// against an arithmetic reference model of PC, retired count and halt state.
module tb_pc_sequencer;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall, halt, resume;
  logic             cond_br, br_taken, uncond_br, br_reg;
  logic [18:0]      imm19;
  logic [25:0]      imm26;
  logic [63:0]      reg_target;
  logic [63:0]      pc, link_addr;
  logic [1:0]       next_sel;
  logic             running;
  logic [CNT_W-1:0] retired;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [63:0]      m_pc;
  logic [CNT_W-1:0] m_ret;
  bit               m_halted;
  logic [63:0]      exp_q[$];

  pc_sequencer #(.RESET_VEC(64'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
    .cond_br(cond_br), .br_taken(br_taken), .uncond_br(uncond_br), .br_reg(br_reg),
    .imm19(imm19), .imm26(imm26), .reg_target(reg_target),
    .pc(pc), .link_addr(link_addr), .next_sel(next_sel), .running(running),
    .retired(retired)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_sel();
    if (br_reg) return 2'd3;
    if (uncond_br) return 2'd2;
    if (cond_br && br_taken) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [63:0] ref_next();
    longint o;
    case (ref_sel())
      2'd1: begin
        o = longint'(imm19);
        if (imm19[18]) o = o - 64'sd524288;
        return m_pc + 64'(o * 4);
      end
      2'd2: begin
        o = longint'(imm26);
        if (imm26[25]) o = o - 64'sd67108864;
        return m_pc + 64'(o * 4);
      end
      2'd3:    return reg_target;
      default: return m_pc + 64'd4;
    endcase
  endfunction

  // driver tasks
  task automatic idle();
    reset = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0;
    cond_br = 1'b0; br_taken = 1'b0; uncond_br = 1'b0; br_reg = 1'b0;
    imm19 = '0; imm26 = '0; reg_target = '0;
  endtask

  // Inputs are set at the falling edge; check combinational outputs, advance the
  // model, clock once, then compare the registered results.
  task automatic step();
    logic [63:0] np;
    logic [63:0] got_pc;
    #1;
    check("next_sel", 64'(next_sel), 64'(ref_sel()));
    check("link_addr", link_addr, m_pc + 64'd4);
    check("running", 64'(running), 64'(!m_halted));
    np = ref_next();
    if (!reset) begin
      m_pc = 64'h0; m_ret = '0; m_halted = 1'b0;
    end else if (m_halted) begin
      if (resume) m_halted = 1'b0;
    end else if (!stall) begin
      m_pc  = np;
      m_ret = m_ret + 1;
      if (halt) m_halted = 1'b1;
    end
    exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    got_pc = pc;
    check("pc", got_pc, exp_q.pop_front());
    check("retired", 64'(retired), 64'(m_ret));
    check("running_q", 64'(running), 64'(!m_halted));
    @(negedge clk);
  endtask

  task automatic goto(input logic [63:0] addr);
    idle(); br_reg = 1'b1; reg_target = addr;
    step();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_pc = 64'h0; m_ret = '0; m_halted = 1'b0;
    check("rst_pc", pc, 64'h0);
    check("rst_retired", 64'(retired), 64'h0);
    check("rst_running", 64'(running), 64'h1);

    // free run
    repeat (3) step();
    check("tp_run_pc", pc, 64'd12);
    check("tp_run_ret", 64'(retired), 64'd3);

    // conditional branch backwards, then not taken
    goto(64'h100);
    cond_br = 1'b1; br_taken = 1'b1; imm19 = 19'h7FFFE;
    #1 check("tp_sel_cond", 64'(next_sel), 64'd1);
    step();
    check("tp_cond_taken", pc, 64'hF8);
    idle(); cond_br = 1'b1; br_taken = 1'b0; imm19 = 19'h7FFFE;
    step();
    check("tp_cond_not", pc, 64'hFC);

    // unconditional, then register over unconditional priority
    goto(64'h40);
    uncond_br = 1'b1; imm26 = 26'h10;
    step();
    check("tp_uncond", pc, 64'h80);
    idle(); br_reg = 1'b1; uncond_br = 1'b1; imm26 = 26'h10; reg_target = 64'h2000;
    #1 check("tp_sel_reg", 64'(next_sel), 64'd3);
    step();
    check("tp_reg", pc, 64'h2000);

    // wrap-around
    goto(64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("tp_wrap", pc, 64'h0);

    // stall
    goto(64'h10);
    stall = 1'b1;
    step(); step();
    check("tp_stall_pc", pc, 64'h10);
    check("tp_stall_ret", 64'(retired), 64'(m_ret));

    // halt and resume
    goto(64'h20);
    halt = 1'b1; resume = 1'b0;
    step();
    check("tp_halt_pc", pc, 64'h24);
    check("tp_halt_run", 64'(running), 64'h0);
    for (int i = 0; i < 5; i++) begin
      idle(); stall = 1'($urandom_range(0, 1)); halt = 1'($urandom_range(0, 1));
      step();
    end
    check("tp_halt_hold", pc, 64'h24);
    idle(); resume = 1'b1;
    step();
    check("tp_resume_pc", pc, 64'h24);
    idle();
    step();
    check("tp_resume_next", pc, 64'h28);

    // reset while halted, then while stalled
    goto(64'h500);
    halt = 1'b1;
    step();
    idle(); reset = 1'b0;
    step();
    check("tp_rst_halt_pc", pc, 64'h0);
    check("tp_rst_halt_run", 64'(running), 64'h1);
    goto(64'h500);
    stall = 1'b1; reset = 1'b0;
    step();
    check("tp_rst_stall_pc", pc, 64'h0);
    check("tp_rst_stall_ret", 64'(retired), 64'h0);

    // randomized
    for (int i = 0; i < 400; i++) begin
      reset      = 1'($urandom_range(0, 49) != 0);
      stall      = 1'($urandom_range(0, 3) == 0);
      halt       = 1'($urandom_range(0, 7) == 0);
      resume     = 1'($urandom_range(0, 3) == 0);
      cond_br    = 1'($urandom_range(0, 1));
      br_taken   = 1'($urandom_range(0, 1));
      uncond_br  = 1'($urandom_range(0, 5) == 0);
      br_reg     = 1'($urandom_range(0, 7) == 0);
      imm19      = 19'($urandom);
      imm26      = 26'($urandom);
      reg_target = {$urandom, $urandom};
      step();
    end

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the single-cycle CPU; holds the 64-bit PC and computes the next PC each cycle.
- Next-PC candidates:
  - sequential (PC+4)
  - PC-relative branch (conditional imm19 or unconditional imm26)
  - register target (BR)
- Drives link_addr (PC+4) as the third input of the write-back 3:1 select used by BL.
- Also provides stall/halt control and a retired-instruction counter.

Parameters:
- RESET_VEC, 64'h0, PC value loaded on reset.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
- stall  input  1  hold PC this cycle (no retire)
- halt  input  1  enter HALTED after current instruction
- resume  input  1  leave HALTED
- cond_br  input  1  conditional-branch instruction
- br_taken  input  1  condition flags satisfied
- uncond_br  input  1  B/BL instruction
- br_reg  input  1  BR instruction
- imm19  input  19  conditional-branch word offset
- imm26  input  26  unconditional-branch word offset
- reg_target  input  64  register value for BR
- pc  output  64  current instruction address
- link_addr  output  64  pc + 4 (combinational), feeds write-back select
- next_sel  output  2  source chosen this cycle: 0 = +4, 1 = cond rel, 2 = uncond rel, 3 = reg
- running  output  1  1 in RUN state
- retired  output  CNT_W  instructions retired since reset

Behaviour:
- Reset (reset==0 at posedge):
  - pc = RESET_VEC, retired = 0, state = RUN.
  - Reset has priority over every other input, including mid-stall or HALTED.
- Offsets:
  - imm19 and imm26 are sign-extended to 64 bits and shifted left 2.
  - Target = pc + offset, modulo 2^64. Wrap-around is allowed, no error.
- next_sel priority (combinational, valid every cycle regardless of state):
  - br_reg → 3
  - else uncond_br → 2
  - else cond_br & br_taken → 1
  - else 0
  - cond_br with br_taken=0 → 0.
- Next-PC mux:
  - 0: pc+4
  - 1: pc+(sext(imm19)<<2)
  - 2: pc+(sext(imm26)<<2)
  - 3: reg_target, used as-is (low 2 bits not masked)
- link_addr = pc + 4 always, independent of state.
- States:
  - RUN:
    - If stall: pc holds, retired holds, stay RUN.
    - Else if halt: pc <= next PC, retired += 1, go HALTED (the halting instruction completes).
    - Else: pc <= next PC, retired += 1.
  - HALTED:
    - pc and retired hold; running = 0; stall and halt are ignored.
    - If resume: go RUN next cycle. The first update occurs in the cycle after that.
- Simultaneous stall and halt in RUN: stall wins; halt must be re-asserted.
- Simultaneous halt and resume in RUN: halt acts, resume is ignored.
- retired wraps from 2^CNT_W-1 to 0 silently.
- Latency:
  - pc updates one clock after the inputs are sampled.
  - next_sel, link_addr and running are combinational from current state and inputs.
- Unknown/X inputs are not handled; the bench drives all control inputs each cycle.

Test Plan:
- Reset then 3 free-running cycles, no branches → pc = 0, 4, 8, 12; retired = 3; next_sel = 0; link_addr = pc+4.
- At pc=0x100:
  - cond_br=1, br_taken=1, imm19=19'h7FFFE → pc = 0xF8, next_sel = 1.
  - Then cond_br=1, br_taken=0 → pc = 0xFC.
- At pc=0x40:
  - uncond_br=1, imm26=26'h10 → pc = 0x80.
  - Then br_reg=1, uncond_br=1, reg_target=0x2000 → pc = 0x2000, next_sel = 3 (priority).
- Wrap-around: pc=64'hFFFF_FFFF_FFFF_FFFC, no branch → pc = 0.
- stall held 2 cycles at pc=0x10 → pc = 0x10, retired unchanged.
- halt asserted at pc=0x20:
  - pc = 0x24, running = 0, holds for 5 cycles despite stall/halt toggling.
  - resume → RUN, pc = 0x28 the cycle after.
- reset driven low while HALTED and while stalled, at pc=0x500 → pc = RESET_VEC, retired = 0, running = 1 next cycle.
